interleaver_serializer: RTL

- Transmit-side counterpart of the 44-bit codeword deinterleaver.
- Accepts 44-bit Hybrid Hamming codewords on a valid/ready parallel interface.
- Applies the 4-row × 11-column block interleave permutation.
- Streams the interleaved word one bit per handshake toward the channel, with a one-word holding buffer so back-to-back words leave without bubbles.

---
 rtl/ilv_pkg.sv | 20 ++
 rtl/interleave_perm.sv | 13 +
 rtl/interleaver_serializer.sv | 113 +++++++++++
 3 files changed

// File: rtl/ilv_pkg.sv
// Shared 4x11 block-interleave definitions for the 44-bit Hybrid Hamming codeword path.
// The deinterleaver and the transmit serializer both take their mapping from ilv_src_index.
package ilv_pkg;

  localparam int unsigned ILV_ROWS  = 4;
  localparam int unsigned ILV_COLS  = 11;
  localparam int unsigned ILV_W     = ILV_ROWS * ILV_COLS;
  localparam int unsigned ILV_IDX_W = $clog2(ILV_W);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } ser_state_e;

  // Interleaved bit i is taken from this codeword bit (row = i mod ROWS, column = i div ROWS).
  function automatic int unsigned ilv_src_index(input int unsigned i);
    return ILV_W - 1 - ILV_COLS * (i % ILV_ROWS) - (i / ILV_ROWS);
  endfunction

endpackage

// File: rtl/interleave_perm.sv
// Purely combinational 4x11 block interleave: Hamming-order codeword in, channel-order word out.
module interleave_perm
  import ilv_pkg::*;
(
  input  logic [ILV_W-1:0] i_word,
  output logic [ILV_W-1:0] o_word
);

  for (genvar g = 0; g < ILV_W; g++) begin : g_perm
    assign o_word[g] = i_word[ilv_src_index(g)];
  end

endmodule

// File: rtl/interleaver_serializer.sv
// Transmit serializer: interleaves 44-bit codewords and streams them one bit per handshake,
// with a one-word holding register so consecutive frames leave without bubbles.
module interleaver_serializer
  import ilv_pkg::*;
#(
  parameter  int unsigned ROWS  = 4,
  parameter  int unsigned COLS  = 11,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned W     = ROWS * COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_sof,
  output logic             ser_eof,
  output logic [CNT_W-1:0] frames_sent,
  output logic             busy
);

  localparam logic [ILV_IDX_W-1:0] IDX_LAST = ILV_IDX_W'(W - 1);

  ser_state_e           r_state, w_state_nxt;
  logic [W-1:0]         r_sr, w_sr_nxt;
  logic [W-1:0]         r_hr, w_hr_nxt;
  logic                 r_hr_full, w_hr_full_nxt;
  logic [ILV_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0]     r_frames, w_frames_nxt;
  logic                 r_in_ready;
  logic [W-1:0]         w_perm;
  logic                 w_accept;

  interleave_perm u_perm (
    .i_word (data_in),
    .o_word (w_perm)
  );

  assign w_accept = in_valid && r_in_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_hr_nxt      = r_hr;
    w_hr_full_nxt = r_hr_full;
    w_idx_nxt     = r_idx;
    w_frames_nxt  = r_frames;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_sr_nxt    = w_perm;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready && (r_idx == IDX_LAST)) begin
          w_frames_nxt = r_frames + 1'b1;
          w_idx_nxt    = '0;
          // HR drains first; a word accepted on the same edge refills HR.
          if (r_hr_full) begin
            w_sr_nxt      = r_hr;
            w_hr_full_nxt = w_accept;
            if (w_accept) w_hr_nxt = w_perm;
          end else if (w_accept) begin
            w_sr_nxt = w_perm;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          if (ser_ready) w_idx_nxt = r_idx + 1'b1;
          if (w_accept) begin
            w_hr_nxt      = w_perm;
            w_hr_full_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_hr       <= '0;
      r_hr_full  <= 1'b0;
      r_idx      <= '0;
      r_frames   <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_sr       <= w_sr_nxt;
      r_hr       <= w_hr_nxt;
      r_hr_full  <= w_hr_full_nxt;
      r_idx      <= w_idx_nxt;
      r_frames   <= w_frames_nxt;
      r_in_ready <= !w_hr_full_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign ser_valid   = (r_state == ST_SHIFT);
  assign ser_data    = (r_state == ST_SHIFT) ? r_sr[r_idx] : 1'b0;
  assign ser_sof     = (r_state == ST_SHIFT) && (r_idx == '0);
  assign ser_eof     = (r_state == ST_SHIFT) && (r_idx == IDX_LAST);
  assign frames_sent = r_frames;
  assign busy        = (r_state == ST_SHIFT) || r_hr_full;

endmodule
